// File: rtl/tx_pkg.sv
// Shared definitions for the serial pattern transmitter and its 1101 detector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//   tx_state_t : transmitter FSM state encoding
//   PREAMBLE   : sync pattern both link ends agree on, sent MSB first
package tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2
  } tx_state_t;

  localparam int          PREAMBLE_LEN = 4;
  localparam logic [3:0]  PREAMBLE     = 4'b1101;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tx_bit_counter.sv
// Loadable down-counter tracking the remaining bits of the current frame phase.
// Latency: load/dec take effect on the next rising edge; zero is combinational from the count.
// Backpressure: none; load has priority over dec.
//   clk, n_rst : clock, asynchronous active-low reset (clears count)
//   load, load_value, dec : control; cnt, zero : current count and its zero flag
module tx_bit_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (dec) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends PREAMBLE then DATA_WIDTH payload bits, MSB first.
// Latency: first preamble bit one edge after acceptance; done PREAMBLE_LEN+DATA_WIDTH+1 edges after it.
// Backpressure: tx_start is ignored while a frame is in flight; each bit waits for a shift_en strobe.
//   clk, n_rst          : clock, asynchronous active-low reset
//   shift_en            : bit-rate strobe ending the current bit period
//   tx_start, tx_data   : frame request and payload (sampled only while idle)
//   serial_out, busy, done : registered line, in-flight flag, completion pulse
module pattern_tx #(
  parameter int                       DATA_WIDTH   = 8,
  parameter int                       PREAMBLE_LEN = 4,
  parameter logic [PREAMBLE_LEN-1:0]  PREAMBLE     = tx_pkg::PREAMBLE
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  shift_en,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  serial_out,
  output logic                  busy,
  output logic                  done
);

  import tx_pkg::*;

  localparam int CNT_W = $clog2(max_int(PREAMBLE_LEN, DATA_WIDTH));
  // Preamble zero-extended to the full counter range so it can be indexed
  // directly by the count without a width mismatch.
  localparam int                PAD_W     = 2 ** CNT_W;
  localparam logic [PAD_W-1:0]  PRE_PAD   = PAD_W'(PREAMBLE);
  localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  tx_state_t              state_q, state_d;
  logic [DATA_WIDTH-1:0]  sreg_q, sreg_d;
  logic                   fin_q, fin_d;
  logic                   serial_out_q, serial_out_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   cnt_load;
  logic [CNT_W-1:0]       cnt_load_value;
  logic                   cnt_dec;
  logic [CNT_W-1:0]       cnt;
  logic                   cnt_zero;

  tx_bit_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .n_rst      (n_rst),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (cnt_dec),
    .cnt        (cnt),
    .zero       (cnt_zero)
  );

  // Next-state logic.
  always_comb begin
    state_d        = state_q;
    sreg_d         = sreg_q;
    fin_d          = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_dec        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          sreg_d         = tx_data;
          cnt_load       = 1'b1;
          cnt_load_value = PRE_LAST;
          state_d        = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        if (shift_en) begin
          if (cnt_zero) begin
            cnt_load       = 1'b1;
            cnt_load_value = DATA_LAST;
            state_d        = S_DATA;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (shift_en) begin
          sreg_d = sreg_q << 1;
          if (cnt_zero) begin
            state_d = S_IDLE;
            fin_d   = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are a registered image of the current Moore state, so every
  // output lags the state by one edge; done trails the DATA->IDLE step.
  always_comb begin
    serial_out_d = 1'b0;
    busy_d       = 1'b0;
    done_d       = fin_q;
    case (state_q)
      S_PREAMBLE: begin
        serial_out_d = PRE_PAD[cnt];
        busy_d       = 1'b1;
      end
      S_DATA: begin
        serial_out_d = sreg_q[DATA_WIDTH-1];
        busy_d       = 1'b1;
      end
      default: begin
        serial_out_d = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      sreg_q       <= '0;
      fin_q        <= 1'b0;
      serial_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      fin_q        <= fin_d;
      serial_out_q <= serial_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign serial_out = serial_out_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx: vector table for a single frame, plus
// hand-written sequences for strobe spacing, busy rejection, back-to-back
// frames and reset during the payload.
module tb_pattern_tx;

  logic       clk;
  logic       n_rst;
  logic       shift_en;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       serial_out;
  logic       busy;
  logic       done;

  int checks;
  int errors;
  int det_cnt;
  int done_cnt;
  logic [3:0] det_win;

  pattern_tx #(
    .DATA_WIDTH   (8),
    .PREAMBLE_LEN (4),
    .PREAMBLE     (4'b1101)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .shift_en   (shift_en),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [7:0] data;
    logic       sen;
    logic [2:0] exp;   // {serial_out, busy, done}
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string nm, input int idx, input logic [2:0] act,
                       input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] ser/busy/done got %b required %b", nm, idx, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", nm, act, exp);
    end
  endtask

  // One clock edge, then sample away from it; also feeds a 1101 detector
  // and a done-pulse counter watching the line.
  task automatic step();
    @(posedge clk);
    #1;
    det_win = {det_win[2:0], serial_out};
    if (det_win == 4'b1101) det_cnt++;
    if (done) done_cnt++;
  endtask

  // Checks edges 1..13 of a frame just accepted at edge 0, with shift_en high.
  // At edge inj (if >0) a competing tx_start with 8'hFF is presented.
  task automatic run_frame(input string nm, input logic [7:0] d, input int inj);
    logic [11:0] fr;
    logic [2:0]  exp;
    fr = {4'b1101, d};
    for (int k = 1; k <= 13; k++) begin
      if (k == inj) begin
        tx_start = 1'b1;
        tx_data  = 8'hFF;
      end else if (inj > 0 && k == inj + 1) begin
        tx_start = 1'b0;
      end
      step();
      if (k <= 12) exp = {fr[12-k], 1'b1, 1'b0};
      else         exp = 3'b001;
      check(nm, k, {serial_out, busy, done}, exp);
    end
  endtask

  initial begin
    logic [11:0] fr;
    logic [2:0]  exp;

    checks   = 0;
    errors   = 0;
    det_cnt  = 0;
    done_cnt = 0;
    det_win  = 4'b0000;
    n_rst    = 1'b1;
    shift_en = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;

    // Asynchronous reset takes effect without a clock edge.
    #2 n_rst = 1'b0;
    #1 check("reset_async", 0, {serial_out, busy, done}, 3'b000);
    #20;
    check("reset_hold", 0, {serial_out, busy, done}, 3'b000);
    n_rst = 1'b1;
    step();
    check("idle", 0, {serial_out, busy, done}, 3'b000);

    // Single frame 8'hA5 with shift_en tied high; tx_data changes after acceptance.
    tbl[0]  = '{1'b1, 8'hA5, 1'b1, 3'b000};
    tbl[1]  = '{1'b0, 8'h5A, 1'b1, 3'b110};
    tbl[2]  = '{1'b0, 8'h5A, 1'b1, 3'b110};
    tbl[3]  = '{1'b0, 8'h5A, 1'b1, 3'b010};
    tbl[4]  = '{1'b0, 8'h5A, 1'b1, 3'b110};
    tbl[5]  = '{1'b0, 8'h5A, 1'b1, 3'b110};
    tbl[6]  = '{1'b0, 8'h5A, 1'b1, 3'b010};
    tbl[7]  = '{1'b0, 8'h5A, 1'b1, 3'b110};
    tbl[8]  = '{1'b0, 8'h5A, 1'b1, 3'b010};
    tbl[9]  = '{1'b0, 8'h5A, 1'b1, 3'b010};
    tbl[10] = '{1'b0, 8'h5A, 1'b1, 3'b110};
    tbl[11] = '{1'b0, 8'h5A, 1'b1, 3'b010};
    tbl[12] = '{1'b0, 8'h5A, 1'b1, 3'b110};
    tbl[13] = '{1'b0, 8'h5A, 1'b1, 3'b001};
    tbl[14] = '{1'b0, 8'h5A, 1'b1, 3'b000};
    for (int i = 0; i < 15; i++) begin
      tx_start = tbl[i].start;
      tx_data  = tbl[i].data;
      shift_en = tbl[i].sen;
      step();
      check("tbl_a5", i, {serial_out, busy, done}, tbl[i].exp);
    end

    // Strobe every 4th edge: each bit held 4 cycles, done on the edge after the last strobe.
    fr = {4'b1101, 8'h3C};
    tx_data = 8'h3C;
    for (int k = 0; k <= 50; k++) begin
      shift_en = ((k % 4) == 0);
      tx_start = (k == 0);
      step();
      if (k >= 1) begin
        if (k <= 48)      exp = {fr[11 - (k - 1) / 4], 1'b1, 1'b0};
        else if (k == 49) exp = 3'b001;
        else              exp = 3'b000;
        check("strobe4", k, {serial_out, busy, done}, exp);
      end
    end
    tx_start = 1'b0;
    shift_en = 1'b1;

    // Busy rejection: a start with 8'hFF mid-frame is ignored, no second frame.
    tx_start = 1'b1;
    tx_data  = 8'h00;
    step();
    tx_start = 1'b0;
    run_frame("reject", 8'h00, 6);
    tx_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("reject_idle", k, {serial_out, busy, done}, 3'b000);
    end

    // Back-to-back: tx_start held high; second frame accepted in the done cycle.
    tx_start = 1'b1;
    tx_data  = 8'h81;
    step();
    tx_data  = 8'h7E;
    run_frame("b2b_first", 8'h81, 0);
    tx_start = 1'b0;
    tx_data  = 8'h00;
    run_frame("b2b_second", 8'h7E, 0);
    step();
    check("b2b_idle", 0, {serial_out, busy, done}, 3'b000);

    // Reset during payload bit 3, then a clean 8'hC3 frame.
    det_cnt  = 0;
    done_cnt = 0;
    det_win  = 4'b0000;
    tx_start = 1'b1;
    tx_data  = 8'h00;
    step();
    tx_start = 1'b0;
    for (int k = 1; k <= 8; k++) step();
    check("pre_abort", 8, {serial_out, busy, done}, 3'b010);
    #2 n_rst = 1'b0;
    #1 check("reset_mid", 0, {serial_out, busy, done}, 3'b000);
    step();
    step();
    check("reset_mid_hold", 0, {serial_out, busy, done}, 3'b000);
    n_rst = 1'b1;
    step();
    check("after_reset", 0, {serial_out, busy, done}, 3'b000);
    tx_start = 1'b1;
    tx_data  = 8'hC3;
    step();
    tx_start = 1'b0;
    tx_data  = 8'h00;
    run_frame("c3_frame", 8'hC3, 0);
    for (int k = 0; k < 6; k++) step();
    check("c3_idle", 0, {serial_out, busy, done}, 3'b000);
    check_int("abort_done_count", done_cnt, 1);
    check_int("preamble_detects", det_cnt, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Bound on total runtime in case the sequence stalls.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
